fifo_drain: RTL and testbench

Read-side controller for a 36-bit FIFO36E2 instance in REGISTERED mode. It drives the FIFO's RDEN from EMPTY and local credit, tracks reads in flight across the FIFO's fixed read latency, and captures returned words into a small skid buffer. The buffer is presented downstream as a valid/ready stream. It sits in the RDCLK domain between the FIFO output (DO/EMPTY) and any consumer that can apply backpressure.

---
 rtl/fifo_drain.sv | 95 +++++++++
 tb/tb_fifo_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// Read-side drain controller for a registered-mode FIFO36E2: issues RDEN on credit,
// tracks reads across the fixed DO latency and presents words as a valid/ready stream.
// Optional transfer counter on port WORDS is enabled by defining FIFO_DRAIN_COUNT_EN.
module fifo_drain #(
  parameter int WIDTH     = 36,
  parameter int LATENCY   = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic             RDCLK,
  input  logic             RST,
  input  logic             EMPTY,
  input  logic [WIDTH-1:0] DO,
  output logic             RDEN,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY
`ifdef FIFO_DRAIN_COUNT_EN
  ,
  output logic [31:0]      WORDS
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + LATENCY + 1) + 1;

  logic [WIDTH-1:0]   mem [BUF_DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;
  logic [LATENCY-1:0] inflight_sr;
  logic [CW-1:0]      inflight;
  logic               pop;
  logic               capture;

  function automatic logic [CW-1:0] popcnt(input logic [LATENCY-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Credit check: words buffered plus words still in the FIFO pipeline, less the
  // one leaving this cycle, must leave room for the new read when it lands.
  always_comb begin
    inflight  = popcnt(inflight_sr);
    capture   = inflight_sr[LATENCY-1];
    OUT_VALID = (count != '0);
    OUT_DATA  = mem[head];
    pop       = OUT_VALID && OUT_READY;
    RDEN      = !RST && !EMPTY &&
                ((count + inflight - CW'(pop)) < CW'(BUF_DEPTH));
  end

  always_ff @(posedge RDCLK or posedge RST) begin
    if (RST) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight_sr <= '0;
    end else begin
      inflight_sr <= (inflight_sr << 1) | LATENCY'(RDEN);
      if (capture) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      count <= count + CW'(capture) - CW'(pop);
    end
  end

  // Storage is cleared too so the head word reads as zero straight out of reset.
  always_ff @(posedge RDCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (capture) begin
      mem[tail] <= DO;
    end
  end

`ifdef FIFO_DRAIN_COUNT_EN
  logic [31:0] words_q;

  always_ff @(posedge RDCLK or posedge RST) begin
    if (RST) begin
      words_q <= '0;
    end else if (pop) begin
      words_q <= words_q + 32'd1;
    end
  end

  assign WORDS = words_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: three instances (LATENCY 1, 2, 4) fed from a FIFO model,
// each checked every cycle against a credit/arrival-time model of the stream.
module tb_fifo_drain;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        force_empty = 1'b0;
  logic        chk_en = 1'b0;
  int          avail = 0;
  logic [35:0] wbase = 36'h1;
  int          checks = 0;
  int          passed = 0;
  int          fails = 0;

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input bit ok, input string nm, input int lat,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s (L=%0d): got %0h, expected %0h", nm, lat, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_l
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    logic        empty;
    logic        rden;
    logic        ovld;
    logic [35:0] do_w = '0;
    logic [35:0] odata;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [31:0] words;
`endif
    int          rd_idx = 0;
    int          n = 0;
    int          dlv = 0;
    bit          rden_s = 1'b0;
    bit          pop_s = 1'b0;
    bit          ev;
    bit          er;
    logic [35:0] pipe [4];
    logic [35:0] mq_w [$];
    int          mq_e [$];

    assign empty = force_empty || (rd_idx >= avail);

    fifo_drain #(.WIDTH(36), .LATENCY(L), .BUF_DEPTH(4)) dut (
      .RDCLK     (clk),
      .RST       (rst),
      .EMPTY     (empty),
      .DO        (do_w),
      .RDEN      (rden),
      .OUT_DATA  (odata),
      .OUT_VALID (ovld),
      .OUT_READY (rdy)
`ifdef FIFO_DRAIN_COUNT_EN
      ,
      .WORDS     (words)
`endif
    );

    always @(posedge rst) begin
      mq_w.delete();
      mq_e.delete();
      rd_idx = 0;
      n = 0;
      dlv = 0;
      rden_s = 1'b0;
      pop_s = 1'b0;
    end

    // FIFO model: a read at edge n is presented on DO for the cycle ending at
    // edge n+L, and becomes visible downstream right after that edge.
    always @(posedge clk) begin
      #1;
      if (!rst) begin
        n++;
        if (pop_s && mq_w.size() > 0) begin
          void'(mq_w.pop_front());
          void'(mq_e.pop_front());
          dlv++;
        end
        for (int j = 3; j > 0; j--) pipe[j] = pipe[j-1];
        if (rden_s) begin
          pipe[0] = wbase + 36'(rd_idx);
          mq_w.push_back(pipe[0]);
          mq_e.push_back(n + L);
          rd_idx++;
        end else begin
          pipe[0] = {4'($urandom), 32'($urandom)};
        end
        do_w = pipe[L-1];
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        rden_s = 1'b0;
        pop_s = 1'b0;
      end else begin
        ev = (mq_e.size() > 0) && (mq_e[0] <= n);
        er = !empty && ((mq_w.size() - ((ev && rdy) ? 1 : 0)) < 4);
        if (chk_en) begin
          chk(ovld === ev, "out_valid", L, 64'(ovld), 64'(ev));
          chk(rden === er, "rden", L, 64'(rden), 64'(er));
          if (ev) chk(odata === mq_w[0], "out_data", L, 64'(odata), 64'(mq_w[0]));
`ifdef FIFO_DRAIN_COUNT_EN
          chk(words === 32'(dlv), "words", L, 64'(words), 64'(dlv));
`endif
        end
        rden_s = rden;
        pop_s = ovld && rdy;
      end
    end
  end

  task automatic chk_reset_state(input string nm);
    chk(g_l[0].rden == 1'b0 && g_l[0].ovld == 1'b0 && g_l[0].odata == 36'h0,
        nm, 1, {g_l[0].rden, g_l[0].ovld, 26'h0, g_l[0].odata}, 64'h0);
    chk(g_l[1].rden == 1'b0 && g_l[1].ovld == 1'b0 && g_l[1].odata == 36'h0,
        nm, 2, {g_l[1].rden, g_l[1].ovld, 26'h0, g_l[1].odata}, 64'h0);
    chk(g_l[2].rden == 1'b0 && g_l[2].ovld == 1'b0 && g_l[2].odata == 36'h0,
        nm, 4, {g_l[2].rden, g_l[2].ovld, 26'h0, g_l[2].odata}, 64'h0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk(g_l[1].words == 32'd0, {nm, "_words"}, 2, 64'(g_l[1].words), 64'h0);
`endif
  endtask

  task automatic chk_all_drained(input string nm);
    chk(g_l[0].dlv == avail, nm, 1, 64'(g_l[0].dlv), 64'(avail));
    chk(g_l[1].dlv == avail, nm, 2, 64'(g_l[1].dlv), 64'(avail));
    chk(g_l[2].dlv == avail, nm, 4, 64'(g_l[2].dlv), 64'(avail));
  endtask

  initial begin
    int first_rd;
    int first_v;
    int last_v;
    int got;
    int pulses;
    int base;
    bit done;

    // Asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #1 chk_reset_state("reset_async");
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk(g_l[1].rden == 1'b0, "rden_idle_empty", 2, 64'(g_l[1].rden), 64'h0);
    end

    // Streaming 0x1..0x10 with the consumer always ready
    @(posedge clk);
    #2 rdy = 1'b1;
    avail = 16;
    first_rd = -1; first_v = -1; last_v = -1; got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (g_l[1].rden && first_rd < 0) first_rd = c;
      if (g_l[1].ovld) begin
        if (first_v < 0) first_v = c;
        chk(g_l[1].odata == 36'(got + 1), "stream_order", 2, 64'(g_l[1].odata), 64'(got + 1));
        got++;
        last_v = c;
      end
    end
    chk(first_v - first_rd == 3, "stream_first_latency", 2, 64'(first_v - first_rd), 64'd3);
    chk(got == 16, "stream_count", 2, 64'(got), 64'd16);
    chk(last_v - first_v == 15, "stream_back_to_back", 2, 64'(last_v - first_v), 64'd15);
`ifdef FIFO_DRAIN_COUNT_EN
    chk(g_l[1].words == 32'd16, "stream_words", 2, 64'(g_l[1].words), 64'd16);
`endif

    // Backpressure: 10 words queued, consumer stalled
    @(posedge clk);
    #2 rdy = 1'b0;
    avail += 10;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (g_l[1].rden) pulses++;
    end
    chk(pulses == 4, "bp_rden_pulses", 2, 64'(pulses), 64'd4);
    chk(g_l[1].ovld == 1'b1, "bp_valid_held", 2, 64'(g_l[1].ovld), 64'd1);
    chk(g_l[1].odata == 36'h11, "bp_head_word", 2, 64'(g_l[1].odata), 64'h11);
    @(posedge clk);
    #2 rdy = 1'b1;
    repeat (30) @(negedge clk);
    chk_all_drained("bp_drained");

    // EMPTY rises after two reads
    @(posedge clk);
    #2 avail += 6;
    base = avail - 6;
    @(posedge clk);
    @(posedge clk);
    #2 force_empty = 1'b1;
    @(negedge clk);
    chk(g_l[1].rden == 1'b0, "empty_rden_drop", 2, 64'(g_l[1].rden), 64'h0);
    repeat (8) @(negedge clk);
    chk(g_l[1].dlv == base + 2, "empty_inflight_delivered", 2, 64'(g_l[1].dlv), 64'(base + 2));
    @(posedge clk);
    #2 force_empty = 1'b0;
    repeat (20) @(negedge clk);
    chk_all_drained("empty_resume");

    // Long randomized run with stalls and EMPTY glitches
    @(posedge clk);
    #2 avail += 1000;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(posedge clk);
      #2;
      rdy = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 9) == 0);
      done = (g_l[0].dlv == avail) && (g_l[1].dlv == avail) && (g_l[2].dlv == avail);
    end
    force_empty = 1'b0;
    rdy = 1'b1;
    repeat (10) @(negedge clk);
    chk_all_drained("random_drained");

    // Reset while words are buffered and in flight
    @(posedge clk);
    #2 rdy = 1'b0;
    avail += 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_state("reset_midflight");
    avail = 0;
    wbase = 36'h9_0000_0000;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    avail = 8;
    rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      if (g_l[1].ovld) begin
        got = 1;
        chk(g_l[1].odata == 36'h9_0000_0000, "reset_first_word", 2,
            64'(g_l[1].odata), 64'h9_0000_0000);
      end
    end
    chk(got == 1, "reset_first_word_seen", 2, 64'(got), 64'd1);
    repeat (30) @(negedge clk);
    chk_all_drained("reset_refill_drained");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
